// File: rtl/hazard_controller.sv
// hazard_controller
//   Decode-stage hazard and flush sequencer. Tracks the destination
//   registers of the instructions in execute, memory and writeback. It
//   stalls decode on a read-after-write hazard. After a taken jump it
//   squashes the wrong-path instructions for SQUASH_CYCLES cycles.
//
//   Optional build macro: HAZARD_FWD_EN
//     defined   - a forwarding datapath exists. Only a load in the
//                 execute-stage entry with a consumer in decode stalls
//                 (the load-use case).
//     undefined - any match in any scoreboard entry stalls decode until
//                 the producing instruction leaves the scoreboard.
//
//   Ports
//     clk          clock, all state on the rising edge
//     rst          synchronous active-low reset
//     a0, a1       rs1 / rs2 of the instruction in decode
//     rs1_used     the decode instruction reads a0
//     rs2_used     the decode instruction reads a1
//     a2_hazard    rd of the instruction in decode
//     dec_reg_wr   the decode instruction writes rd
//     dec_mem_re   the decode instruction is a load
//     jmp_taken    execute resolved a taken jump this cycle
//     stall        hold fetch/decode; a bubble enters execute
//     squash       kill the instruction currently in decode
//     stall_cnt    saturating count of stall cycles
//     squash_cnt   saturating count of squash cycles
//
//   Flush FSM states
//     state | meaning
//     IDLE  | no flush in progress; squash follows jmp_taken only
//     FLUSH | holding squash after a taken jump; flush_cnt cycles remain

module hazard_controller #(
    parameter int SB_DEPTH      = 3,
    parameter int SQUASH_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       a0,
    input  logic [4:0]       a1,
    input  logic             rs1_used,
    input  logic             rs2_used,
    input  logic [4:0]       a2_hazard,
    input  logic             dec_reg_wr,
    input  logic             dec_mem_re,
    input  logic             jmp_taken,
    output logic             stall,
    output logic             squash,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(SQUASH_CYCLES - 1);

    state_t              state;
    logic [2:0]          flush_cnt;

    logic [SB_DEPTH-1:0] sb_valid;
    logic [SB_DEPTH-1:0] sb_load;
    logic [4:0]          sb_rd [SB_DEPTH];

    logic [SB_DEPTH-1:0] sb_elig;
    logic                hit_rs1;
    logic                hit_rs2;
    logic                push_valid;

    // Entries that are allowed to cause a stall.
    always_comb begin
        sb_elig = '0;
`ifdef HAZARD_FWD_EN
        // ALU results are forwarded; only a load one stage ahead must wait.
        sb_elig[0] = sb_valid[0] & sb_load[0];
`else
        sb_elig = sb_valid;
`endif
    end

    always_comb begin
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb_elig[i] && rs1_used && (a0 != 5'd0) && (sb_rd[i] == a0))
                hit_rs1 = 1'b1;
            if (sb_elig[i] && rs2_used && (a1 != 5'd0) && (sb_rd[i] == a1))
                hit_rs2 = 1'b1;
        end
    end

    // jmp_taken feeds squash directly so the wrong-path instruction is killed
    // in the same cycle the jump resolves.
    assign squash     = jmp_taken | (state == FLUSH);
    assign stall      = ~squash & (hit_rs1 | hit_rs2);
    assign push_valid = dec_reg_wr & (a2_hazard != 5'd0) & ~stall & ~squash;

    // Scoreboard shift register; stalled or squashed cycles push a bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sb_valid <= '0;
            sb_load  <= '0;
            for (int i = 0; i < SB_DEPTH; i++)
                sb_rd[i] <= 5'd0;
        end else begin
            sb_valid[0] <= push_valid;
            sb_load[0]  <= dec_mem_re;
            sb_rd[0]    <= a2_hazard;
            for (int i = 1; i < SB_DEPTH; i++) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_load[i]  <= sb_load[i-1];
                sb_rd[i]    <= sb_rd[i-1];
            end
        end
    end

    // Flush FSM. A jump during a flush restarts the hold period.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            flush_cnt <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (jmp_taken && (SQUASH_CYCLES > 1)) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_RELOAD;
                    end
                end
                FLUSH: begin
                    if (jmp_taken) begin
                        flush_cnt <= FLUSH_RELOAD;
                    end else if (flush_cnt == 3'd1) begin
                        state     <= IDLE;
                        flush_cnt <= 3'd0;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    flush_cnt <= 3'd0;
                end
            endcase
        end
    end

    // Performance counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt  <= '0;
            squash_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (squash && (squash_cnt != '1))
                squash_cnt <= squash_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

    localparam int CNT_W = 16;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [4:0]       a0;
    logic [4:0]       a1;
    logic             rs1_used;
    logic             rs2_used;
    logic [4:0]       a2_hazard;
    logic             dec_reg_wr;
    logic             dec_mem_re;
    logic             jmp_taken;
    logic             stall;
    logic             squash;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] squash_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] exp_q [$];

    hazard_controller #(
        .SB_DEPTH      (3),
        .SQUASH_CYCLES (2),
        .CNT_W         (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a0         (a0),
        .a1         (a1),
        .rs1_used   (rs1_used),
        .rs2_used   (rs2_used),
        .a2_hazard  (a2_hazard),
        .dec_reg_wr (dec_reg_wr),
        .dec_mem_re (dec_mem_re),
        .jmp_taken  (jmp_taken),
        .stall      (stall),
        .squash     (squash),
        .stall_cnt  (stall_cnt),
        .squash_cnt (squash_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running, want finished");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    // One decode cycle: drive inputs just after the rising edge, queue the
    // expected {stall, squash}, compare at the falling edge, then advance.
    task automatic step(input string tag,
                        input logic [4:0] s0, input logic u0,
                        input logic [4:0] s1, input logic u1,
                        input logic [4:0] rd, input logic wr, input logic ld,
                        input logic jmp,
                        input logic exp_stall, input logic exp_squash);
        logic [1:0] e;
        a0         = s0;
        rs1_used   = u0;
        a1         = s1;
        rs2_used   = u1;
        a2_hazard  = rd;
        dec_reg_wr = wr;
        dec_mem_re = ld;
        jmp_taken  = jmp;
        exp_q.push_back({exp_stall, exp_squash});
        @(negedge clk);
        e = exp_q.pop_front();
        check_val({tag, ".stall"},  32'(stall),  32'(e[1]));
        check_val({tag, ".squash"}, 32'(squash), 32'(e[0]));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step("idle", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst        = 1'b0;
        a0         = 5'd0;
        a1         = 5'd0;
        rs1_used   = 1'b0;
        rs2_used   = 1'b0;
        a2_hazard  = 5'd0;
        dec_reg_wr = 1'b0;
        dec_mem_re = 1'b0;
        jmp_taken  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset with a jump held: nothing must survive release.
        step("rst", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("rst.stall_cnt",  32'(stall_cnt),  0);
        check_val("rst.squash_cnt", 32'(squash_cnt), 0);

        // ALU RAW on rs1.
        step("raw.prod", 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("raw.cons", 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, !FWD, 1'b0);
        step("raw.go", 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("raw.stall_cnt", 32'(stall_cnt), FWD ? 0 : 3);
        idle(3);

        // Matching register but source not read: no stall.
        step("unused.prod", 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("unused.cons", 5'd5, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Load-use on rs2: one stall even with forwarding.
        step("ld.prod", 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ld.use0", 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("ld.use1", 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, !FWD, 1'b0);
        step("ld.use2", 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, !FWD, 1'b0);
        step("ld.go",   5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("ld.stall_cnt", 32'(stall_cnt), FWD ? 1 : 6);
        idle(3);

        // x0 never creates a hazard.
        step("x0.prod", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("x0.cons", 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Both sources match the same producer: still one stall per cycle.
        step("dual.prod", 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("dual.cons", 5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, !FWD, 1'b0);
        step("dual.go", 5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("dual.stall_cnt", 32'(stall_cnt), FWD ? 1 : 9);
        idle(3);

        // Jump concurrent with a hazard: squash wins for two cycles.
        step("jmp.prod", 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("jmp.t0",   5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step("jmp.t1",   5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("jmp.t2",   5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("jmp.squash_cnt", 32'(squash_cnt), 2);
        check_val("jmp.stall_cnt",  32'(stall_cnt),  FWD ? 1 : 9);
        idle(3);

        // Back-to-back jumps extend the flush by one cycle.
        step("b2b.t0", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step("b2b.t1", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step("b2b.t2", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("b2b.t3", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("b2b.squash_cnt", 32'(squash_cnt), 5);

        // Reset in the middle of a flush aborts it and clears the counters.
        step("mid.jmp", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        step("mid.rst", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        step("mid.post", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("mid.squash_cnt", 32'(squash_cnt), 0);
        check_val("mid.stall_cnt",  32'(stall_cnt),  0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
